// File: rtl/input_debounce.sv
// Two-flop synchronizer plus per-bit settle filter for a bank of async inputs.
// A new level is accepted only after STABLE_CYCLES+1 consecutive stable samples.
module input_debounce #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] out_q;
  state_e           state_q [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [WIDTH-1:0] settle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        unique case (state_q[i])
          IDLE: begin
            if (s2_q[i] != out_q[i]) begin
              state_q[i] <= SETTLE;
              cnt_q[i]   <= CNT_ONE;
            end else begin
              cnt_q[i] <= '0;
            end
          end
          SETTLE: begin
            // Any sample back at the old level discards the whole window.
            if (s2_q[i] == out_q[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              out_q[i]   <= s2_q[i];
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    settle = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      settle[i] = (state_q[i] == SETTLE);
    end
  end

  assign busy = |settle;
  assign out  = out_q;

endmodule
